// File: rtl/ttl_defs.sv
// Shared definitions for the serial capture blocks: FSM encodings and a
// constant-function clog2 for sizing counters from parameters.
package ttl_defs;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Plain serial-in shift register; direction selects which end ds enters.
// qh is the oldest bit, i.e. the one about to fall off the far end.
module sipo_shreg
  import ttl_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic             dir,
  input  logic             ds,
  output logic [WIDTH-1:0] sr,
  output logic             qh
);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sr <= '0;
    end else if (en) begin
      if (dir) sr <= {sr[WIDTH-2:0], ds};
      else     sr <= {ds, sr[WIDTH-1:1]};
    end
  end

  assign qh = dir ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel word capture with sync alignment, a holding register,
// valid/ack handshake and a sticky overrun flag.
//
// state | meaning
// HUNT  | waiting for sync; bits are discarded
// SHIFT | bits are assembled into words
module sipo_deserializer
  import ttl_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int SYNC_MODE = 1
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     shift_en,
  input  logic                     ds,
  input  logic                     sync,
  input  logic                     q_ack,
  input  logic                     ovr_clr,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic                     overrun,
  output logic                     qh,
  output logic [clog2(WIDTH):0]    bit_cnt
);

  localparam int               CW       = clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam state_t           ST_RESET = (SYNC_MODE != 0) ? HUNT : SHIFT;
  localparam logic             DIR      = (MSB_FIRST != 0);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             complete;
  logic             shift_go;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word_nxt;

  // A sync strobe with shift_en captures its bit even from HUNT.
  assign shift_go = shift_en && (state == SHIFT || sync);
  assign word_nxt = DIR ? {sr[WIDTH-2:0], ds} : {ds, sr[WIDTH-1:1]};

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk  (clk),
    .nRST (nRST),
    .en   (shift_go),
    .dir  (DIR),
    .ds   (ds),
    .sr   (sr),
    .qh   (qh)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state   <= ST_RESET;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    complete  = 1'b0;
    if (sync) begin
      state_nxt = SHIFT;
      cnt_nxt   = shift_en ? CW'(1) : '0;
    end else if (shift_en && state == SHIFT) begin
      if (bit_cnt == LAST) begin
        cnt_nxt  = '0;
        complete = 1'b1;
      end else begin
        cnt_nxt  = bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete) begin
        q       <= word_nxt;
        q_valid <= 1'b1;
      end else if (q_ack) begin
        q_valid <= 1'b0;
      end
      // set beats clear when both land on the same edge
      if (complete && q_valid && !q_ack) overrun <= 1'b1;
      else if (ovr_clr)                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: three instances (LSB-first synced, MSB-first synced,
// LSB-first free-running) share one stimulus stream.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic nRST, shift_en, ds, sync, q_ack, ovr_clr;

  logic [7:0] q_l, q_m, q_f;
  logic       v_l, v_m, v_f, o_l, o_m, o_f, qh_l, qh_m, qh_f;
  logic [3:0] c_l, c_m, c_f;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0), .SYNC_MODE(1)) u_lsb (
    .clk(clk), .nRST(nRST), .shift_en(shift_en), .ds(ds), .sync(sync),
    .q_ack(q_ack), .ovr_clr(ovr_clr), .q(q_l), .q_valid(v_l),
    .overrun(o_l), .qh(qh_l), .bit_cnt(c_l));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1), .SYNC_MODE(1)) u_msb (
    .clk(clk), .nRST(nRST), .shift_en(shift_en), .ds(ds), .sync(sync),
    .q_ack(q_ack), .ovr_clr(ovr_clr), .q(q_m), .q_valid(v_m),
    .overrun(o_m), .qh(qh_m), .bit_cnt(c_m));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0), .SYNC_MODE(0)) u_free (
    .clk(clk), .nRST(nRST), .shift_en(shift_en), .ds(ds), .sync(sync),
    .q_ack(q_ack), .ovr_clr(ovr_clr), .q(q_f), .q_valid(v_f),
    .overrun(o_f), .qh(qh_f), .bit_cnt(c_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[0] first; the MSB-first instance therefore sees rev8(w).
  task automatic send_word(input logic [7:0] w, input bit with_sync, input bit ack_last);
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1;
      ds       = w[i];
      sync     = with_sync && (i == 0);
      q_ack    = ack_last && (i == 7);
      tick();
    end
    shift_en = 1'b0; sync = 1'b0; q_ack = 1'b0;
    e = exp_q.pop_front();
    chk("q_lsb", q_l, e);
    chk("q_msb", q_m, rev8(e));
    chk("qv_lsb", v_l, 1);
    chk("cnt_lsb", c_l, 0);
    chk("qh_lsb", qh_l, e[0]);
    chk("qh_msb", qh_m, e[0]);
  endtask

  task automatic ack();
    q_ack = 1'b1; tick(); q_ack = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; shift_en = 1'b0; ds = 1'b0; sync = 1'b0; q_ack = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    chk("rst_q", q_l, 0);
    chk("rst_qv", v_l, 0);
    chk("rst_ovr", o_l, 0);
    chk("rst_cnt", c_l, 0);
    chk("rst_qh", qh_l, 0);
    nRST = 1'b1;
    tick();

    // HUNT ignores shift_en without sync
    ds = 1'b1;
    for (int i = 0; i < 3; i++) begin shift_en = 1'b1; tick(); end
    shift_en = 1'b0;
    chk("hunt_cnt", c_l, 0);
    chk("hunt_qv", v_l, 0);

    send_word(8'hA5, 1'b1, 1'b0);
    ack();
    chk("ack_clr", v_l, 0);
    ack();
    chk("ack_idle", v_l, 0);

    send_word(8'hF0, 1'b1, 1'b0);
    ack();

    // back-to-back, no ack -> overrun
    send_word(8'h3C, 1'b1, 1'b0);
    chk("ovr_first", o_l, 0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("ovr_set", o_l, 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ovr_clr", o_l, 0);
    chk("ovr_clr_qv", v_l, 1);
    ack();

    // ack on the completing edge of the second word
    send_word(8'h3C, 1'b1, 1'b0);
    send_word(8'hC3, 1'b0, 1'b1);
    chk("ackcomp_ovr", o_l, 0);
    ack();

    // five bits, then resync with ds=1 and seven more
    for (int i = 0; i < 5; i++) begin
      shift_en = 1'b1; ds = i[0]; sync = (i == 0); tick();
    end
    sync = 1'b0; shift_en = 1'b0;
    chk("part_cnt", c_l, 5);
    exp_q.push_back(8'h5B);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h5B;
      shift_en = 1'b1; ds = w[i]; sync = (i == 0);
      if (i == 7) chk("resync_nocomp", v_l, 0);
      tick();
      if (i == 0) chk("resync_cnt", c_l, 1);
    end
    shift_en = 1'b0; sync = 1'b0;
    e = exp_q.pop_front();
    chk("resync_q", q_l, e);
    chk("resync_b0", q_l[0], 1);
    chk("resync_qv", v_l, 1);
    ack();

    // sync at bit_cnt==WIDTH-1 suppresses completion
    for (int i = 0; i < 7; i++) begin
      shift_en = 1'b1; ds = 1'b1; sync = (i == 0); tick();
    end
    chk("cnt7", c_l, 7);
    sync = 1'b1; tick();
    chk("sync7_qv", v_l, 0);
    chk("sync7_cnt", c_l, 1);
    sync = 1'b1; shift_en = 1'b0; tick(); sync = 1'b0;
    chk("sync_noen_cnt", c_l, 0);

    // async reset mid-word
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1; ds = 1'b1; sync = (i == 0); tick();
    end
    shift_en = 1'b0; sync = 1'b0;
    chk("mid_cnt", c_l, 4);
    #3 nRST = 1'b0;
    #1;
    chk("arst_q", q_l, 0);
    chk("arst_qv", v_l, 0);
    chk("arst_cnt", c_l, 0);
    chk("arst_qh", qh_l, 0);
    chk("arst_ovr", o_l, 0);
    chk("arst_q_free", q_f, 0);
    chk("arst_qv_free", v_f, 0);
    tick();
    nRST = 1'b1;

    // free-running instance captures without sync
    exp_q.push_back(8'h96);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h96;
      shift_en = 1'b1; ds = w[i]; tick();
    end
    shift_en = 1'b0;
    e = exp_q.pop_front();
    chk("free_q", q_f, e);
    chk("free_qv", v_f, 1);
    chk("free_cnt", c_f, 0);
    chk("hunt_after_rst_qv", v_l, 0);
    chk("hunt_after_rst_cnt", c_l, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
